// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: multi-cycle shift-and-add multiplier, unsigned or two's complement
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d, prod_q, prod_d, fin;
  logic [WIDTH:0]       mplier_q, mplier_d, a_mag, b_mag;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d, sgn_q, sgn_d, ovf_q, ovf_d, done_q, done_d, fin_ovf;
  assign a_mag   = (signed_mode && a[WIDTH-1]) ? -{1'b1, a} : {1'b0, a};
  assign b_mag   = (signed_mode && b[WIDTH-1]) ? -{1'b1, b} : {1'b0, b};
  assign fin     = neg_q ? -acc_q : acc_q;
  // signed results fit only when the top WIDTH+1 bits are a pure sign extension
  assign fin_ovf = sgn_q ? ~(&fin[2*WIDTH-1:WIDTH-1] | ~|fin[2*WIDTH-1:WIDTH-1])
                         : |fin[2*WIDTH-1:WIDTH];
  assign ready    = (state_q == S_IDLE) && !done_q;
  assign busy     = state_q == S_RUN;
  assign done     = done_q;
  assign product  = prod_q;
  assign result   = prod_q[WIDTH-1:0];
  assign overflow = ovf_q;
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: if (start && ready) begin
        mcand_d  = {{(WIDTH-1){1'b0}}, a_mag};
        mplier_d = b_mag;
        acc_d    = '0;
        cnt_d    = '0;
        neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        sgn_d    = signed_mode;
        state_d  = S_RUN;
      end
      S_RUN: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        state_d  = (cnt_q == CW'(WIDTH-1)) ? S_FIN : S_RUN;
      end
      S_FIN: begin
        prod_d  = fin;
        ovf_d   = fin_ovf;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: directed and random checks of 4-bit and 8-bit multipliers
module tb_seq_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst4, start4, sm4, rdy4, busy4, done4, o4;
  logic [3:0] a4, b4, r4;
  logic [7:0] p4;
  logic rst8, start8, sm8, rdy8, busy8, done8, o8;
  logic [7:0] a8, b8, r8;
  logic [15:0] p8;
  int checks = 0, errors = 0, npulse4 = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (done4) npulse4++;
  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
    .ready(rdy4), .busy(busy4), .done(done4), .product(p4), .result(r4), .overflow(o4));
  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .ready(rdy8), .busy(busy8), .done(done8), .product(p8), .result(r8), .overflow(o8));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic op(input bit w8, input logic sm, input logic [7:0] x, input logic [7:0] y,
                    input logic [15:0] ep, input logic eo, input string tag);
    int k;
    logic dn;
    if (w8) begin sm8 = sm; a8 = x; b8 = y; start8 = 1'b1; end
    else begin sm4 = sm; a4 = x[3:0]; b4 = y[3:0]; start4 = 1'b1; end
    @(posedge clk); #1;
    start4 = 1'b0; start8 = 1'b0;
    k = 0; dn = 1'b0;
    while (!dn && k < 30) begin
      @(posedge clk); #1;
      k++;
      dn = w8 ? done8 : done4;
    end
    chk({tag, "_lat"}, 16'(k), w8 ? 16'd9 : 16'd5);
    chk({tag, "_prod"}, w8 ? p8 : {8'h00, p4}, ep);
    chk({tag, "_res"}, w8 ? 16'(r8) : 16'(r4), w8 ? 16'(ep[7:0]) : 16'(ep[3:0]));
    chk({tag, "_ovf"}, w8 ? 16'(o8) : 16'(o4), 16'(eo));
    @(posedge clk); #1;
    chk({tag, "_rdy"}, w8 ? 16'(rdy8) : 16'(rdy4), 16'd1);
    chk({tag, "_dn0"}, w8 ? 16'(done8) : 16'(done4), 16'd0);
  endtask
  initial begin
    int n0, k, sx, sy, pr;
    logic [7:0] x, y;
    logic sm;
    rst4 = 1'b1; rst8 = 1'b1; start4 = 1'b0; start8 = 1'b0;
    sm4 = 1'b0; sm8 = 1'b0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1 rst4 = 1'b0; rst8 = 1'b0;
    chk("rst_ready", 16'(rdy4), 16'd1);
    chk("rst_busy", 16'(busy4), 16'd0);
    chk("rst_done", 16'(done4), 16'd0);
    chk("rst_prod", 16'(p4), 16'd0);
    chk("rst_ovf", 16'(o4), 16'd0);
    chk("rst_prod8", p8, 16'd0);
    op(1'b0, 1'b0, 8'd3, 8'd5, 16'h000F, 1'b0, "u3x5");
    op(1'b0, 1'b0, 8'd15, 8'd15, 16'h00E1, 1'b1, "u15x15");
    op(1'b0, 1'b1, 8'hE, 8'd3, 16'h00FA, 1'b0, "sm2x3");
    op(1'b0, 1'b1, 8'h8, 8'h8, 16'h0040, 1'b1, "sm8xm8");
    op(1'b0, 1'b1, 8'hD, 8'd5, 16'h00F1, 1'b1, "sm3x5");
    op(1'b0, 1'b1, 8'h0, 8'h8, 16'h0000, 1'b0, "s0xm8");
    op(1'b0, 1'b0, 8'hF, 8'h0, 16'h0000, 1'b0, "u15x0");
    op(1'b0, 1'b0, 8'd7, 8'd6, 16'h002A, 1'b1, "u7x6");
    // start during RUN with new operands must be ignored
    n0 = npulse4;
    sm4 = 1'b0; a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    chk("run_busy", 16'(busy4), 16'd1);
    chk("run_nrdy", 16'(rdy4), 16'd0);
    chk("run_hold", 16'(p4), 16'h2A);
    repeat (2) @(posedge clk);
    #1 a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    k = 0;
    while (!done4 && k < 30) begin @(posedge clk); #1 k++; end
    chk("ign_prod", 16'(p4), 16'h0F);
    repeat (12) @(posedge clk);
    #1 chk("ign_pulses", 16'(npulse4 - n0), 16'd1);
    op(1'b0, 1'b0, 8'd15, 8'd15, 16'h00E1, 1'b1, "pre_rst");
    // reset mid-RUN abandons the operation
    a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    @(posedge clk); #1 rst4 = 1'b1;
    @(posedge clk); #1 rst4 = 1'b0;
    chk("mrst_ready", 16'(rdy4), 16'd1);
    chk("mrst_busy", 16'(busy4), 16'd0);
    chk("mrst_prod", 16'(p4), 16'd0);
    chk("mrst_res", 16'(r4), 16'd0);
    chk("mrst_ovf", 16'(o4), 16'd0);
    n0 = npulse4;
    repeat (10) @(posedge clk);
    #1 chk("mrst_nodone", 16'(npulse4 - n0), 16'd0);
    op(1'b0, 1'b0, 8'd3, 8'd5, 16'h000F, 1'b0, "post_rst");
    op(1'b1, 1'b0, 8'd255, 8'd255, 16'hFE01, 1'b1, "u255x255");
    op(1'b1, 1'b1, 8'h80, 8'h80, 16'h4000, 1'b1, "sm128sq");
    op(1'b1, 1'b1, 8'h80, 8'h01, 16'hFF80, 1'b0, "sm128x1");
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom); y = 8'($urandom); sm = 1'($urandom);
      sx = sm ? int'($signed(x)) : int'(x);
      sy = sm ? int'($signed(y)) : int'(y);
      pr = sx * sy;
      op(1'b1, sm, x, y, pr[15:0], sm ? (pr < -128 || pr > 127) : (pr > 255), "rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
